// File: rtl/wb_master_seq.sv
// Single-outstanding Wishbone classic-cycle master: one command in, one bus cycle, one response out.
// A bus cycle with no ack from the slave is abandoned after TIMEOUT cycles and answered with an error.
module wb_master_seq #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [DW-1:0] cmd_dat_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_dat_o,
  output logic          rsp_err_o,
  output logic          master_cyc_o,
  output logic          master_stb_o,
  output logic          master_we_o,
  output logic [DW-1:0] master_dat_o,
  input  logic          master_ack_i,
  input  logic [DW-1:0] master_dat_i,
  output logic [CW-1:0] xfer_cnt_o
);

  // Handshake rule for both ports: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds valid and its payload stable until that edge.

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;
  logic          rsp_err_q, rsp_err_d;
  logic [CW-1:0] xfer_q, xfer_d;
  logic [TW-1:0] to_q, to_d;

  // cyc/stb and the port handshakes are pure decodes of the state register, so they never glitch.
  assign cmd_ready_o  = (state_q == IDLE);
  assign master_cyc_o = (state_q == BUS);
  assign master_stb_o = (state_q == BUS);
  assign rsp_valid_o  = (state_q == RESP);
  assign master_we_o  = we_q;
  assign master_dat_o = wdat_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_err_o    = rsp_err_q;
  assign xfer_cnt_o   = xfer_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      wdat_q    <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      xfer_q    <= '0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      wdat_q    <= wdat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      xfer_q    <= xfer_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    wdat_d    = wdat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    xfer_d    = xfer_q;
    to_d      = to_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          wdat_d  = cmd_dat_i;
          to_d    = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // An ack arriving on the timeout cycle still wins.
        if (master_ack_i) begin
          rsp_dat_d = master_dat_i;
          rsp_err_d = 1'b0;
          xfer_d    = xfer_q + CW'(1);
          state_d   = RESP;
        end else if ((TIMEOUT != 0) && (to_q == TO_LAST)) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      RESP: begin
        // A late registered ack from the slave lands here and is dropped.
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed bench for wb_master_seq with a registered-ack slave model that leaves ack high one cycle after stb drops.
module tb_wb_master_seq;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [DW-1:0] cmd_dat;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_dat;
  logic          m_cyc, m_stb, m_we, m_ack;
  logic [DW-1:0] m_dat_o, m_dat_i;
  logic [CW-1:0] xfer_cnt;

  logic          slave_en;
  logic [DW-1:0] slave_param;
  logic [DW-1:0] slave_wdat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_master_seq #(.DW(DW), .TIMEOUT(4), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .master_cyc_o(m_cyc), .master_stb_o(m_stb), .master_we_o(m_we), .master_dat_o(m_dat_o),
    .master_ack_i(m_ack), .master_dat_i(m_dat_i), .xfer_cnt_o(xfer_cnt)
  );

  // Slave: ack follows stb by one cycle with no self-clear, so it lingers one cycle after stb drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_ack      <= 1'b0;
      slave_wdat <= '0;
    end else begin
      m_ack <= slave_en & m_cyc & m_stb;
      if (m_cyc && m_stb && m_we) slave_wdat <= m_dat_o;
    end
  end
  assign m_dat_i = slave_param;

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_dat = '0;
    rsp_ready = 1'b0; slave_en = 1'b1; slave_param = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_cyc, m_stb, m_we, rsp_valid, rsp_err, cmd_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctrl got cyc/stb/we/rv/err/rdy=%b want 000001",
               {m_cyc, m_stb, m_we, rsp_valid, rsp_err, cmd_ready});
    end
    checks++;
    if ({m_dat_o, rsp_dat} !== 64'h0) begin
      errors++; $display("FAIL reset_data got dat_o=%h rsp_dat=%h want 0/0", m_dat_o, rsp_dat);
    end
    checks++;
    if (xfer_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", xfer_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    slave_param = 32'h5A;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_dat = 32'hDEADBEEF;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL wr_ready got %b want 1", cmd_ready);
    end
    @(negedge clk);  // cycle 1
    cmd_valid = 1'b0;
    checks++;
    if ({m_cyc, m_stb, m_we, cmd_ready} !== 4'b1110 || m_dat_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_cycle1 got cyc/stb/we/rdy=%b dat_o=%h want 1110 deadbeef",
                         {m_cyc, m_stb, m_we, cmd_ready}, m_dat_o);
    end
    @(negedge clk);  // cycle 2
    checks++;
    if ({m_cyc, m_stb, rsp_valid} !== 3'b110) begin
      errors++; $display("FAIL wr_cycle2 got cyc/stb/rv=%b want 110", {m_cyc, m_stb, rsp_valid});
    end
    @(negedge clk);  // cycle 3
    $display("slave_dat_i=%h", slave_wdat);
    checks++;
    if ({m_cyc, m_stb, rsp_valid, rsp_err} !== 4'b0010 || rsp_dat !== 32'h5A) begin
      errors++; $display("FAIL wr_rsp got cyc/stb/rv/err=%b dat=%h want 0010 0000005a",
                         {m_cyc, m_stb, rsp_valid, rsp_err}, rsp_dat);
    end
    checks++;
    if (xfer_cnt !== 2'd1) begin
      errors++; $display("FAIL wr_cnt got %0d want 1", xfer_cnt);
    end
    checks++;
    if (slave_wdat !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_slave_data got %h want deadbeef", slave_wdat);
    end
    rsp_ready = 1'b1;
    @(negedge clk);  // cycle 4
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, m_cyc} !== 3'b010) begin
      errors++; $display("FAIL wr_idle got rv/rdy/cyc=%b want 010", {rsp_valid, cmd_ready, m_cyc});
    end
  endtask

  task automatic test_read();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_dat = 32'h1234;
    @(negedge clk);  // cycle 1
    cmd_valid = 1'b0;
    checks++;
    if ({m_cyc, m_stb, m_we} !== 3'b110 || m_dat_o !== 32'h1234) begin
      errors++; $display("FAIL rd_cycle1 got cyc/stb/we=%b dat_o=%h want 110 00001234",
                         {m_cyc, m_stb, m_we}, m_dat_o);
    end
    repeat (2) @(negedge clk);  // cycle 3, stale ack is high now
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_dat !== 32'h5A || xfer_cnt !== 2'd2) begin
      errors++; $display("FAIL rd_rsp got rv/err=%b dat=%h cnt=%0d want 10 0000005a 2",
                         {rsp_valid, rsp_err}, rsp_dat, xfer_cnt);
    end
    rsp_ready = 1'b1;
    @(negedge clk);  // cycle 4
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rsp_valid, m_cyc, cmd_ready} !== 3'b001 || xfer_cnt !== 2'd2) begin
        errors++; $display("FAIL rd_no_dup[%0d] got rv/cyc/rdy=%b cnt=%0d want 001 2",
                           i, {rsp_valid, m_cyc, cmd_ready}, xfer_cnt);
      end
      @(negedge clk);
    end
  endtask

  // Stalled response, then a command held valid through the stall becomes the timeout case.
  task automatic test_stall_timeout();
    slave_param = 32'h77;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_dat = 32'hA5A5A5A5;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);  // cycle 3
    checks++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'h77 || xfer_cnt !== 2'd3) begin
      errors++; $display("FAIL st_rsp got rv=%b dat=%h cnt=%0d want 1 00000077 3", rsp_valid, rsp_dat, xfer_cnt);
    end
    slave_param = 32'h99;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_dat = 32'hCAFE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_err, cmd_ready, m_cyc} !== 4'b1000 || rsp_dat !== 32'h77) begin
        errors++; $display("FAIL st_hold[%0d] got rv/err/rdy/cyc=%b dat=%h want 1000 00000077",
                           i, {rsp_valid, rsp_err, cmd_ready, m_cyc}, rsp_dat);
      end
    end
    rsp_ready = 1'b1; slave_en = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, m_cyc} !== 3'b010) begin
      errors++; $display("FAIL st_release got rv/rdy/cyc=%b want 010", {rsp_valid, cmd_ready, m_cyc});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if ({m_cyc, m_stb, rsp_valid} !== 3'b110) begin
        errors++; $display("FAIL to_stb[%0d] got cyc/stb/rv=%b want 110", i, {m_cyc, m_stb, rsp_valid});
      end
    end
    @(negedge clk);
    checks++;
    if ({m_cyc, m_stb, rsp_valid, rsp_err} !== 4'b0011 || rsp_dat !== 32'h0) begin
      errors++; $display("FAIL to_rsp got cyc/stb/rv/err=%b dat=%h want 0011 00000000",
                         {m_cyc, m_stb, rsp_valid, rsp_err}, rsp_dat);
    end
    checks++;
    if (xfer_cnt !== 2'd3) begin
      errors++; $display("FAIL to_cnt got %0d want 3", xfer_cnt);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; slave_en = 1'b1;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL to_idle got rv/rdy=%b want 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_reset_mid_bus();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_dat = 32'h13572468;
    @(negedge clk);  // cycle 1
    cmd_valid = 1'b0;
    checks++;
    if (m_cyc !== 1'b1) begin
      errors++; $display("FAIL rst_bus_pre got cyc=%b want 1", m_cyc);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({m_cyc, m_stb, rsp_valid, cmd_ready} !== 4'b0001 || xfer_cnt !== 2'd0) begin
        errors++; $display("FAIL rst_bus[%0d] got cyc/stb/rv/rdy=%b cnt=%0d want 0001 0",
                           i, {m_cyc, m_stb, rsp_valid, cmd_ready}, xfer_cnt);
      end
      @(negedge clk);
    end
  endtask

  // Drives one command from IDLE and waits (bounded) for its response, then completes the handshake.
  task automatic run_xfer(input logic we, input logic [DW-1:0] dat, output logic [DW-1:0] rdat,
                          output logic rerr, output logic [CW-1:0] cnt, output int lat);
    cmd_valid = 1'b1; cmd_we = we; cmd_dat = dat;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdat = rsp_dat; rerr = rsp_err; cnt = xfer_cnt;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] rdat;
    logic          rerr;
    logic [CW-1:0] cnt;
    int            lat;
    for (int k = 0; k < 4; k++) begin
      slave_param = 32'h11 * (k + 1);
      run_xfer(k[0], 32'h100 + k, rdat, rerr, cnt, lat);
      checks++;
      if (lat !== 3) begin
        errors++; $display("FAIL wrap_lat[%0d] got %0d want 3", k, lat);
      end
      checks++;
      if (rdat !== 32'h11 * (k + 1) || rerr !== 1'b0) begin
        errors++; $display("FAIL wrap_rsp[%0d] got dat=%h err=%b want %h 0", k, rdat, rerr, 32'h11 * (k + 1));
      end
      checks++;
      if (cnt !== CW'((k + 1) % 4)) begin
        errors++; $display("FAIL wrap_cnt[%0d] got %0d want %0d", k, cnt, (k + 1) % 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stall_timeout();
    test_reset_mid_bus();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
